// File: rtl/rv_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: FSM states, word widths
// and the RV32I major opcodes used by the decoder and the testbench.
package rv_fetch_pkg;

  localparam int INSTR_W  = 32;
  localparam int OPCODE_W = 7;

  // F0..F3 fetch byte lane 0..3; HOLD presents the assembled word.
  typedef enum logic [2:0] {
    F0   = 3'd0,
    F1   = 3'd1,
    F2   = 3'd2,
    F3   = 3'd3,
    HOLD = 3'd4
  } fetch_state_t;

  localparam logic [OPCODE_W-1:0] OP_IMM = 7'b0010011;
  localparam logic [OPCODE_W-1:0] OP     = 7'b0110011;
  localparam logic [OPCODE_W-1:0] LOAD   = 7'b0000011;
  localparam logic [OPCODE_W-1:0] STORE  = 7'b0100011;
  localparam logic [OPCODE_W-1:0] BRANCH = 7'b1100011;
  localparam logic [OPCODE_W-1:0] JAL    = 7'b1101111;

  // Byte lane fetched in a given state; HOLD reads lane 0 so the address
  // bus sits on the word's own PC while waiting for the decoder.
  function automatic logic [1:0] lane_of(fetch_state_t s);
    return (s == HOLD) ? 2'd0 : s[1:0];
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch stage: walks a byte-wide instruction memory four bytes at
// a time, assembles a little-endian 32-bit word and offers it to the decoder
// over valid/ready. A redirect restarts fetch at a word-aligned target.
module instr_fetch
  import rv_fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [7:0]          mem_rdata,
  input  logic                redirect_valid,
  input  logic [ADDR_W-1:0]   redirect_pc,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [INSTR_W-1:0]  instr,
  output logic [ADDR_W-1:0]   instr_pc,
  output logic [OPCODE_W-1:0] opcode
);

  localparam logic [ADDR_W-1:0] START_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        lane;

  // Byte address for the lane being fetched; wraps naturally at 2^ADDR_W.
  always_comb begin
    // NOTE: every always_comb output gets a value on every path, so no latch
    // can be inferred even if a later edit adds a conditional branch.
    lane     = lane_of(state);
    mem_addr = pc + ADDR_W'(lane);
  end

  assign opcode = instr[OPCODE_W-1:0];

  // Fetch FSM: byte capture, PC update, handshake and redirect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the assembled word and its PC are reset as well, not just the
      // control state, because they are visible outputs with defined reset
      // values; leaving them X would leak into the decoder's opcode.
      state       <= F0;
      pc          <= START_PC;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins over everything, including a handshake in HOLD: the
      // presented word counts as consumed and the target replaces pc + 4.
      // NOTE: state registers use non-blocking assignments so every
      // right-hand side sees the pre-edge value regardless of statement order.
      pc          <= {redirect_pc[ADDR_W-1:2], 2'b00};
      state       <= F0;
      instr_valid <= 1'b0;
    end else begin
      if (state != HOLD) begin
        instr[{lane, 3'b000} +: 8] <= mem_rdata;
      end
      case (state)
        F0: state <= F1;
        F1: state <= F2;
        F2: state <= F3;
        F3: begin
          state       <= HOLD;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
        end
        HOLD: begin
          if (instr_ready) begin
            pc          <= pc + ADDR_W'(4);
            state       <= F0;
            instr_valid <= 1'b0;
          end
        end
        default: begin
          state       <= F0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
